// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_tx_pkg
// Brief    : Shared state encoding, line levels and frame-length helper for
//            the configurable UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Clock cycles from acceptance until the line returns to idle.
    function automatic int frame_len(input int data_width, input int clks_per_bit,
                                     input logic par_en, input logic stop2);
        return clks_per_bit * (2 + data_width + (par_en ? 1 : 0) + (stop2 ? 1 : 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Prescale counter; bit_end marks the last clock of every bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_single
            // Every clock is a whole bit, so no counter is needed.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, restart};
            assign bit_end       = 1'b1;
        end else begin : g_count
            localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || restart) begin
                    cnt <= '0;
                end else if (cnt == LAST_CNT) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign bit_end = (cnt == LAST_CNT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Brief    : Parametrised UART transmitter with optional parity, selectable
//            second stop bit, input capture and a frame-done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int               IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_next;
    logic                  stop_second;
    logic                  stop_second_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic                  accept;
    logic                  bit_end;
    logic                  timer_restart;
    logic                  parity_bit;
    logic                  line_next;

    assign accept        = Data_valid && !busy;
    assign timer_restart = (state == IDLE);
    assign parity_bit    = (^data_q) ^ par_typ_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (CLK),
        .rst    (RST),
        .restart(timer_restart),
        .bit_end(bit_end)
    );

    always_comb begin
        state_next       = state;
        bit_idx_next     = bit_idx;
        stop_second_next = stop_second;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next       = START;
                    bit_idx_next     = '0;
                    stop_second_next = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_IDX) begin
                        state_next   = par_en_q ? PARITY : STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_second) begin
                        stop_second_next = 1'b1;
                    end else begin
                        state_next       = IDLE;
                        stop_second_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line register is loaded with the level of the upcoming cycle.
        line_next = LINE_IDLE;
        case (state_next)
            START:   line_next = START_BIT;
            DATA:    line_next = data_q[bit_idx_next];
            PARITY:  line_next = parity_bit;
            default: line_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            stop2_q     <= 1'b0;
            TX_OUT      <= LINE_IDLE;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state       <= state_next;
            bit_idx     <= bit_idx_next;
            stop_second <= stop_second_next;
            TX_OUT      <= line_next;
            busy        <= (state_next != IDLE);
            tx_done     <= (state == STOP) && (state_next == IDLE);
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                stop2_q   <= STOP2;
            end
        end
    end

endmodule
`default_nettype wire
